// File: rtl/txd_frame_sink_if.sv
// Committed-byte output stream of txd_frame_sink: byte, end-of-frame flag and valid/ready handshake.
interface txd_frame_sink_if;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_last, output m_valid, input m_ready);
    modport slave  (input m_data, input m_last, input m_valid, output m_ready);
endinterface

// File: rtl/txd_frame_sink.sv
// Store-and-forward sink for the txd/tx_en byte stream: buffers whole frames, reports length/sum,
// drops frames that are oversize or do not fit, and replays committed frames on a valid/ready stream.
module txd_frame_sink #(
    parameter int DEPTH   = 64,
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              txd,
    input  logic                    tx_en,
    txd_frame_sink_if.master        m,
    output logic                    frm_done,
    output logic [LEN_W-1:0]        frm_len,
    output logic [7:0]              frm_sum,
    output logic                    drop_pulse,
    output logic [7:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0]      DEPTH_V   = (PW + 1)'(DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;

    state_t           state;
    logic [8:0]       mem [DEPTH];
    logic [PW-1:0]    wr_spec;
    logic [PW-1:0]    wr_commit;
    logic [PW-1:0]    rd_ptr;
    logic [7:0]       stg_data;
    logic             stg_valid;
    logic [LEN_W-1:0] len;
    logic [7:0]       sum;

    logic [PW:0]      occupancy;
    logic [LEN_W-1:0] cur_len;
    logic             accept;
    logic             wr_en;
    logic             wr_last;
    logic             pop;

    // Space check uses the registered rd_ptr, so a same-cycle pop never frees room for the incoming byte.
    always_comb begin
        occupancy = {1'b0, wr_spec - rd_ptr} + {{PW{1'b0}}, stg_valid};
        cur_len   = (state == RECV) ? len : '0;
        accept    = (occupancy < DEPTH_V) && (cur_len < MAX_LEN_V);
        wr_en     = rst_n && (state == RECV) && (!tx_en || accept);
        wr_last   = !tx_en;
        pop       = m.m_valid && m.m_ready;
    end

    assign m.m_valid = (rd_ptr != wr_commit);
    assign m.m_data  = m.m_valid ? mem[rd_ptr[AW-1:0]][7:0] : 8'd0;
    assign m.m_last  = m.m_valid ? mem[rd_ptr[AW-1:0]][8]   : 1'b0;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_spec[AW-1:0]] <= {wr_last, stg_data};
    end

    // The newest byte waits in staging so it can be written with the right last flag once we know
    // whether another byte follows; a rejected byte rolls wr_spec back to discard the partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_spec    <= '0;
            wr_commit  <= '0;
            rd_ptr     <= '0;
            stg_data   <= '0;
            stg_valid  <= 1'b0;
            len        <= '0;
            sum        <= '0;
            frm_done   <= 1'b0;
            frm_len    <= '0;
            frm_sum    <= '0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            frm_done   <= 1'b0;
            drop_pulse <= 1'b0;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: begin
                    if (tx_en) begin
                        if (accept) begin
                            stg_data  <= txd;
                            stg_valid <= 1'b1;
                            len       <= LEN_W'(1);
                            sum       <= txd;
                            state     <= RECV;
                        end else begin
                            state <= DISCARD;
                        end
                    end
                end
                RECV: begin
                    if (tx_en) begin
                        if (accept) begin
                            wr_spec  <= wr_spec + 1'b1;
                            stg_data <= txd;
                            len      <= len + 1'b1;
                            sum      <= sum + txd;
                        end else begin
                            wr_spec   <= wr_commit;
                            stg_valid <= 1'b0;
                            state     <= DISCARD;
                        end
                    end else begin
                        wr_spec   <= wr_spec + 1'b1;
                        wr_commit <= wr_spec + 1'b1;
                        stg_valid <= 1'b0;
                        frm_done  <= 1'b1;
                        frm_len   <= len;
                        frm_sum   <= sum;
                        state     <= IDLE;
                    end
                end
                DISCARD: begin
                    if (!tx_en) begin
                        drop_pulse <= 1'b1;
                        if (drop_cnt != 8'hFF)
                            drop_cnt <= drop_cnt + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/txd_frame_sink.md
Name: txd_frame_sink

Overview:
- Downstream consumer of the data wrapper's txd/tx_en byte stream.
- Delimits frames: one frame is a contiguous run of cycles with tx_en high.
- Store-and-forward: buffers each complete frame, reports its length and mod-256 byte sum, then releases its bytes on a valid/ready stream with an end-of-frame marker.
- Drops whole frames that are oversize or that do not fit in the buffer.

Parameters:
- DEPTH, 64: buffer size in bytes; power of 2; must be >= MAX_LEN.
- MAX_LEN, 32: maximum accepted frame length in bytes.
- LEN_W, $clog2(MAX_LEN+1): width of frm_len.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- txd  in  8  frame byte from the data wrapper; sampled when tx_en=1.
- tx_en  in  1  frame-active qualifier.
- m_data  out  8  head byte of the committed buffer.
- m_last  out  1  m_data is the final byte of its frame.
- m_valid  out  1  a committed byte is available.
- m_ready  in  1  consumer accepts the byte; a pop occurs when m_valid && m_ready.
- frm_done  out  1  one-cycle pulse: a frame was committed.
- frm_len  out  LEN_W  length of the last committed frame; held until the next commit.
- frm_sum  out  8  mod-256 sum of the last committed frame's bytes; held until the next commit.
- drop_pulse  out  1  one-cycle pulse: a frame was discarded.
- drop_cnt  out  8  count of discarded frames; saturates at 255.

Behaviour:
- Reset (rst_n=0 at a posedge):
  - All outputs are 0.
  - rd_ptr, wr_spec and wr_commit are cleared; the staging register is emptied.
  - State returns to IDLE.
  - A frame in progress is lost silently and does not increment drop_cnt.
- Buffer entries are 9 bits wide: {last, byte}.
- Pointers:
  - wr_spec: speculative write pointer.
  - wr_commit: committed write pointer.
  - rd_ptr: read pointer.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- Staging register: holds the most recent byte. It is written to the buffer with last=0 when the next byte arrives, or with last=1 when the frame ends.
- occupancy = (wr_spec - rd_ptr) + staged. It uses the registered rd_ptr, so a pop in the same cycle does not free space.
- Byte acceptance rule: a byte is accepted iff occupancy < DEPTH and len < MAX_LEN.
- Write FSM states:
  - IDLE:
    - tx_en=1 and the byte is accepted: stage txd, len=1, sum=txd, go to RECV.
    - tx_en=1 and the byte is not accepted: go to DISCARD.
  - RECV, tx_en=1:
    - Byte accepted: push the staged byte (last=0), stage txd, len+1, sum+txd mod 256.
    - Byte not accepted: wr_spec rolls back to wr_commit, staging is cleared, go to DISCARD.
  - RECV, tx_en=0 (commit):
    - Write the staged byte with last=1.
    - wr_commit <= wr_spec+1.
    - Load frm_len and frm_sum.
    - Go to IDLE.
  - DISCARD:
    - Ignore bytes until tx_en=0.
    - At that edge: drop_pulse=1 for one cycle, drop_cnt increments (saturating), go to IDLE.
- Latency: for a frame of N bytes, tx_en is high in cycles 0..N-1 and low in cycle N. Then:
  - frm_done is high in cycle N+1.
  - m_valid can first rise in cycle N+1.
- Minimum gap between frames is 1 idle cycle. A new frame may start in the cycle right after the commit edge.
- Read side:
  - m_valid = (rd_ptr != wr_commit).
  - m_data and m_last are read combinationally from the buffer at rd_ptr.
  - rd_ptr increments on a pop.
  - Uncommitted bytes are never visible on the read side.
  - A pop and a commit in the same cycle are both honoured.
- Empty buffer: m_valid=0 and m_ready is ignored.
- Full buffer: new frame bytes cause a discard. Committed data is never overwritten.

Test Plan:
1. Frame 110,120,130 (tx_en high 3 cycles), m_ready=1 -> frm_done in cycle 4 with frm_len=3, frm_sum=0x68; m_data 110,120,130 on consecutive cycles, m_last only on 130.
2. Single-cycle frame 0xFF -> frm_len=1, frm_sum=0xFF; one beat with m_last=1.
3. 33-byte frame (MAX_LEN+1) -> no frm_done; drop_pulse once after tx_en falls; drop_cnt=1; m_valid stays 0. The next 2-byte frame {1,2} commits normally.
4. m_ready=0; two 32-byte frames, then 1-byte frame 0x55 -> two frm_done pulses; 0x55 is dropped (drop_cnt=1). With m_ready=1, 64 beats drain with m_last at beats 32 and 64.
5. Frames {1,2}, one idle cycle, then {3} -> two frm_done pulses 2 cycles apart: (len 2, sum 3), then (len 1, sum 3). Stream reads 1,2(last),3(last).
6. rst_n low for 1 cycle after 2 bytes of a frame -> all outputs 0 and drop_cnt=0. A following frame {7} gives frm_len=1, frm_sum=7.
